ieee_host_ctrl: RTL and testbench
=================================

Name: ieee_host_ctrl

Overview:
- Computer-side IEEE-488 controller-in-charge and talker/listener engine for the CBM-II core; the initiator counterpart to the disk drive subsystem.
- A CPU-side request interface drives it. It sources bytes with ATN/EOI using the source handshake (DAV), accepts bytes using the acceptor handshake (NRFD/NDAC), pulses IFC, and reports timeout and device-not-present status.
- bus_o is wired-ANDed with the drive subsystem's bus output at top level.

Parameters:
- SETTLE, 32: ce ticks that data/ATN/EOI must be stable before DAV is asserted (2 µs at 16 MHz).
- TIMEOUT, 1024: ce ticks to wait for any single handshake edge before aborting (64 µs).
- IFC_LEN, 1600: ce ticks IFC is held low (100 µs).

Ports:
- clk_sys  in  1: system clock.
- reset  in  1: reset, synchronous, active-low.
- ce  in  1: 16 MHz clock-enable. All counters advance only when ce=1; FSM edges are evaluated every clk_sys.
- req_valid  in  1: request present.
- req_ready  out  1: high only in IDLE. A request is accepted on the clk_sys cycle where req_valid && req_ready.
- req_op  in  2: 00 send byte, 01 receive byte, 10 IFC pulse, 11 release ATN.
- req_data  in  8: byte to send.
- req_atn  in  1: send the byte as a command (ATN low).
- req_eoi  in  1: assert EOI with the byte.
- rsp_valid  out  1: one-cycle pulse on completion of any op.
- rsp_data  out  8: received byte. Valid with rsp_valid for op 01; holds its last value otherwise.
- rsp_eoi  out  1: EOI was low when the received byte was latched.
- rsp_status  out  2: 00 ok, 01 timeout, 10 device not present.
- busy  out  1: not IDLE.
- bus_i  in  st_ieee_bus: synchronised bus state.
- bus_o  out  st_ieee_bus: this node's drive.

Bus signal convention:
- All st_ieee_bus signals are asserted low; 1 means released.
- bus_o.data carries the inverted byte (~req_data) when sending.

Behaviour:
- Reset (reset=0):
  - FSM returns to IDLE.
  - All bus_o fields are 1 (bus released), including ATN.
  - rsp_valid=0, rsp_data=0, rsp_eoi=0, rsp_status=00.
  - All counters are cleared.
- Reset mid-operation releases the bus on the next clk_sys edge and produces no rsp_valid.
- ATN latch:
  - ATN is registered. Op 00 with req_atn=1 drives it low; op 11 releases it.
  - It persists across ops, so a command sequence followed by a data phase is possible.
  - Op 00 with req_atn=0 does not change ATN.
- States: IDLE, S_SETTLE, S_DAV, S_REL, A_RDY, A_WAITHI, IFC, DONE.
- Send (op 00):
  - IDLE→S_SETTLE. Drive data, drive EOI low if req_eoi, update ATN, release NRFD/NDAC, clear the counter.
  - At entry, if bus_i.nrfd=1 and bus_i.ndac=1 (no listener), go to DONE with status 10.
  - In S_SETTLE the counter counts ce ticks. After SETTLE ticks and bus_i.nrfd=1, assert DAV → S_DAV.
  - In S_DAV, wait for bus_i.ndac=1 → S_REL. S_REL releases DAV, data and EOI → DONE with status 00.
  - Timeout in S_SETTLE or S_DAV: release DAV, data and EOI; keep ATN; DONE with status 01.
- Receive (op 01):
  - IDLE→A_RDY. ATN must already be released; if ATN is latched low, go to DONE with status 10 and do not touch the handshake lines.
  - In A_RDY: release NRFD, hold NDAC low.
  - When bus_i.dav=0, latch ~bus_i.data into rsp_data and ~bus_i.eoi into rsp_eoi in the same cycle, assert NRFD, release NDAC → A_WAITHI.
  - A_WAITHI: wait for bus_i.dav=1, then assert NDAC → DONE with status 00. NRFD remains low until the next request.
  - A_RDY has no timeout: a talker may delay indefinitely, and the CPU aborts via reset or IFC.
  - A_WAITHI times out after TIMEOUT ticks: NDAC asserted, status 01.
- IFC (op 10):
  - Drive IFC low for IFC_LEN ce ticks, release ATN at the same time, then → DONE with status 00.
- Release ATN (op 11): release ATN → DONE with status 00. No other bus effect.
- DONE:
  - Lasts exactly one cycle: rsp_valid=1 → IDLE.
  - rsp_status holds until the next DONE.
- Latency: req accept to first bus_o change is 1 clk_sys cycle.
- Timeout counter: width clog2(max(TIMEOUT,IFC_LEN,SETTLE))+1. Reset on every state entry; saturates, no wrap.
- Simultaneous events:
  - req_valid while busy is ignored, since req_ready=0.
  - If an edge and a timeout are both true in the same cycle, the edge wins.
- bus_o.srq and bus_o.ren are always 1.

Test Plan:
- Send $28 with ATN=1 to a model listener (NRFD/NDAC handshake with 3 µs delays): ATN low, bus data $D7, DAV low no earlier than 32 ce ticks after data, rsp_status=00, DAV/data released, ATN still low.
- Send with both NRFD and NDAC released (no device): rsp_valid one cycle after accept, status 10, DAV never asserted.
- Listener never releases NDAC: DAV stays low for 1024 ce ticks, then released; status 01.
- After op 11, receive from a talker sending $41 with EOI: rsp_data=$41, rsp_eoi=1, status 00, NRFD/NDAC sequencing matches the acceptor handshake.
- IFC op during latched ATN: IFC low for exactly 1600 ce ticks, ATN released at start, status 00; then reset=0 asserted mid-send releases all lines next cycle with no rsp_valid.

Source files
------------

// File: rtl/ieee_host_ctrl.sv
// IEEE-488 controller-in-charge for the CBM-II core: sources and accepts bytes
// with the three-wire handshake, pulses IFC and tracks the ATN latch.
package ieee_host_pkg;
  // All lines are active low; an all-ones value means the bus is released.
  typedef struct packed {
    logic [7:0] data;
    logic       atn;
    logic       eoi;
    logic       dav;
    logic       nrfd;
    logic       ndac;
    logic       ifc;
    logic       srq;
    logic       ren;
  } st_ieee_bus;

  localparam st_ieee_bus BUS_RELEASED = st_ieee_bus'('1);
endpackage

module ieee_host_ctrl
  import ieee_host_pkg::*;
#(
  parameter int SETTLE  = 32,
  parameter int TIMEOUT = 1024,
  parameter int IFC_LEN = 1600
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ce,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  input  logic       req_atn,
  input  logic       req_eoi,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_eoi,
  output logic [1:0] rsp_status,
  output logic       busy,
  input  st_ieee_bus bus_i,
  output st_ieee_bus bus_o
);

  localparam int MAX_A   = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int MAX_LEN = (IFC_LEN > MAX_A) ? IFC_LEN : MAX_A;
  localparam int CW      = $clog2(MAX_LEN) + 1;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] IFC_LAST = CW'(IFC_LEN - 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_TO  = 2'b01;
  localparam logic [1:0] ST_NDP = 2'b10;

  typedef enum logic [2:0] {
    IDLE, S_SETTLE, S_DAV, S_REL, A_RDY, A_WAITHI, IFC, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          entry;
  logic          timed_out;
  logic          unused_bus;

  // A timeout fires on the ce tick that completes the TIMEOUT-th tick in a state.
  assign timed_out  = ce && (cnt >= TO_LAST);
  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign unused_bus = ^{bus_i.atn, bus_i.ifc, bus_i.srq, bus_i.ren};

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state      <= IDLE;
      bus_o      <= BUS_RELEASED;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_eoi    <= 1'b0;
      rsp_status <= ST_OK;
      cnt        <= '0;
      entry      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (ce && cnt != CNT_MAX) cnt <= cnt + CW'(1);
      case (state)
        IDLE: if (req_valid) begin
          cnt <= '0;
          case (req_op)
            2'b00: begin
              bus_o.data <= ~req_data;
              bus_o.eoi  <= ~req_eoi;
              if (req_atn) bus_o.atn <= 1'b0;
              bus_o.nrfd <= 1'b1;
              bus_o.ndac <= 1'b1;
              entry      <= 1'b1;
              state      <= S_SETTLE;
            end
            2'b01: if (!bus_o.atn) begin
              // Receiving under a latched command phase makes no sense; refuse it.
              state      <= DONE;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_NDP;
            end else begin
              bus_o.nrfd <= 1'b1;
              bus_o.ndac <= 1'b0;
              state      <= A_RDY;
            end
            2'b10: begin
              bus_o.ifc <= 1'b0;
              bus_o.atn <= 1'b1;
              state     <= IFC;
            end
            default: begin
              bus_o.atn  <= 1'b1;
              state      <= DONE;
              rsp_valid  <= 1'b1;
              rsp_status <= ST_OK;
            end
          endcase
        end
        S_SETTLE: begin
          entry <= 1'b0;
          if (entry && bus_i.nrfd && bus_i.ndac) begin
            bus_o.data <= 8'hFF;
            bus_o.eoi  <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_NDP;
          end else if (cnt >= SETTLE_C && bus_i.nrfd) begin
            bus_o.dav <= 1'b0;
            cnt       <= '0;
            state     <= S_DAV;
          end else if (timed_out) begin
            bus_o.data <= 8'hFF;
            bus_o.eoi  <= 1'b1;
            cnt        <= '0;
            state      <= DONE;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_TO;
          end
        end
        S_DAV: if (bus_i.ndac) begin
          cnt   <= '0;
          state <= S_REL;
        end else if (timed_out) begin
          bus_o.dav  <= 1'b1;
          bus_o.data <= 8'hFF;
          bus_o.eoi  <= 1'b1;
          cnt        <= '0;
          state      <= DONE;
          rsp_valid  <= 1'b1;
          rsp_status <= ST_TO;
        end
        S_REL: begin
          bus_o.dav  <= 1'b1;
          bus_o.data <= 8'hFF;
          bus_o.eoi  <= 1'b1;
          cnt        <= '0;
          state      <= DONE;
          rsp_valid  <= 1'b1;
          rsp_status <= ST_OK;
        end
        A_RDY: if (!bus_i.dav) begin
          rsp_data   <= ~bus_i.data;
          rsp_eoi    <= ~bus_i.eoi;
          bus_o.nrfd <= 1'b0;
          bus_o.ndac <= 1'b1;
          cnt        <= '0;
          state      <= A_WAITHI;
        end
        A_WAITHI: if (bus_i.dav || timed_out) begin
          bus_o.ndac <= 1'b0;
          cnt        <= '0;
          state      <= DONE;
          rsp_valid  <= 1'b1;
          rsp_status <= bus_i.dav ? ST_OK : ST_TO;
        end
        IFC: if (ce && cnt >= IFC_LAST) begin
          bus_o.ifc  <= 1'b1;
          cnt        <= '0;
          state      <= DONE;
          rsp_valid  <= 1'b1;
          rsp_status <= ST_OK;
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ieee_host_ctrl.sv
// Bench for ieee_host_ctrl: a wired-AND bus with scripted listener/talker
// devices, a response scoreboard and a per-cycle idle-state model.
module tb_ieee_host_ctrl;
  import ieee_host_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ce = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       req_atn = 1'b0;
  logic       req_eoi = 1'b0;
  logic       req_ready, rsp_valid, rsp_eoi, busy;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  st_ieee_bus bus_i, bus_o, dev;

  assign bus_i = st_ieee_bus'(bus_o & dev);

  ieee_host_ctrl dut (
    .clk_sys(clk), .reset(reset), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_atn(req_atn), .req_eoi(req_eoi),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_eoi(rsp_eoi),
    .rsp_status(rsp_status), .busy(busy), .bus_i(bus_i), .bus_o(bus_o)
  );

  // Clock / clock-enable: ce is high on every other clk cycle.
  always #5 clk = ~clk;
  always @(posedge clk) ce <= ~ce;

  // Scoreboard state: {op[1:0], status[1:0], data[7:0], eoi}
  logic [12:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        model_atn = 1'b1;
  logic [7:0]  model_rx = 8'h00;
  logic        model_eoi = 1'b0;
  logic [1:0]  model_status = 2'b00;
  int          settle_ticks = 0;
  int          dav_low_ticks = 0;
  int          ifc_low_ticks = 0;
  logic        dav_seen = 1'b0;
  logic        run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  // Compare process: response scoreboard plus idle-state model every cycle.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        check("req_ready vs busy", 32'(req_ready), 32'(!busy));
        check("srq/ren released", 32'({bus_o.srq, bus_o.ren}), 32'(2'b11));
        if (ce) begin
          if (bus_o.data != 8'hFF && bus_o.dav) settle_ticks++;
          if (!bus_o.dav) dav_low_ticks++;
          if (!bus_o.ifc) ifc_low_ticks++;
        end
        if (!bus_o.dav) dav_seen = 1'b1;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected rsp_valid", 32'(rsp_valid), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("rsp_status", 32'(rsp_status), 32'(e[10:9]));
            if (e[12:11] == 2'b01 && e[10:9] != 2'b10) begin
              check("rsp_data", 32'(rsp_data), 32'(e[8:1]));
              check("rsp_eoi", 32'(rsp_eoi), 32'(e[0]));
              model_rx  = e[8:1];
              model_eoi = e[0];
            end
            model_status = e[10:9];
          end
        end
        if (!busy) begin
          check("idle atn latch", 32'(bus_o.atn), 32'(model_atn));
          check("idle dav released", 32'(bus_o.dav), 32'(1));
          check("idle ifc released", 32'(bus_o.ifc), 32'(1));
          check("held rsp_data", 32'(rsp_data), 32'(model_rx));
          check("held rsp_eoi", 32'(rsp_eoi), 32'(model_eoi));
          check("held rsp_status", 32'(rsp_status), 32'(model_status));
        end
      end
    end
  end

  // Driver: present one request at a negedge; it is accepted on the next posedge.
  task automatic issue(input logic [1:0] op, input logic [7:0] d, input logic a,
                       input logic eo, input logic [1:0] st, input logic [7:0] rd,
                       input logic re);
    @(negedge clk);
    check("req_ready before issue", 32'(req_ready), 32'(1));
    req_op = op; req_data = d; req_atn = a; req_eoi = eo; req_valid = 1'b1;
    settle_ticks = 0; dav_low_ticks = 0; ifc_low_ticks = 0; dav_seen = 1'b0;
    exp_q.push_back({op, st, rd, re});
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (op == 2'b00 && a) model_atn = 1'b0;
    if (op == 2'b10 || op == 2'b11) model_atn = 1'b1;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < budget);
    if (busy) check({name, " completion wait expired"}, 32'(busy), 32'(0));
  endtask

  function automatic logic bus_field(input int which);
    case (which)
      0:       return bus_i.dav;
      1:       return bus_i.nrfd;
      2:       return bus_i.ndac;
      default: return bus_i.nrfd & !bus_i.ndac;
    endcase
  endfunction

  task automatic wait_bus(input int which, input logic val, input int budget, input string name);
    int k;
    k = 0;
    while (bus_field(which) !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (bus_field(which) !== val) check({name, " wait expired"}, 32'(bus_field(which)), 32'(val));
  endtask

  task automatic wait_ce(input int n);
    repeat (n) begin
      @(negedge clk);
      while (!ce) @(negedge clk);
    end
  endtask

  // Listener: ready at once, accepts with 48-tick (3 us) delays.
  task automatic listener(input logic [7:0] exp_byte);
    logic [7:0] b;
    dev = BUS_RELEASED;
    dev.ndac = 1'b0;
    wait_bus(0, 1'b0, 3000, "listener dav low");
    b = ~bus_i.data;
    check("listener byte", 32'(b), 32'(exp_byte));
    check("listener sees atn low", 32'(bus_i.atn), 32'(0));
    dev.nrfd = 1'b0;
    wait_ce(48);
    dev.ndac = 1'b1;
    wait_bus(0, 1'b1, 3000, "listener dav high");
    dev.ndac = 1'b0;
  endtask

  // Talker: waits for acceptor ready, sources one byte, optionally holds DAV.
  task automatic talker(input logic [7:0] b, input logic eoi_low, input logic hold);
    logic [7:0] nb;
    nb = ~b;
    dev = BUS_RELEASED;
    wait_bus(3, 1'b1, 3000, "talker acceptor ready");
    dev.data = nb;
    dev.eoi  = !eoi_low;
    wait_ce(4);
    dev.dav = 1'b0;
    wait_bus(2, 1'b1, 3000, "talker ndac release");
    check("acceptor nrfd asserted", 32'(bus_i.nrfd), 32'(0));
    if (!hold) begin
      dev.dav  = 1'b1;
      dev.data = 8'hFF;
      dev.eoi  = 1'b1;
    end
  endtask

  initial begin
    #1500000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    int lat;
    dev = BUS_RELEASED;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset bus_o", 32'(bus_o), 32'(16'hFFFF));
    check("reset rsp_valid", 32'(rsp_valid), 32'(0));
    check("reset rsp_data", 32'(rsp_data), 32'(0));
    check("reset rsp_eoi", 32'(rsp_eoi), 32'(0));
    check("reset rsp_status", 32'(rsp_status), 32'(0));
    check("reset req_ready", 32'(req_ready), 32'(1));
    reset = 1'b1;
    run_cmp = 1'b1;
    repeat (4) @(negedge clk);

    // Command byte $28 with ATN to a live listener.
    fork
      listener(8'h28);
      begin
        issue(2'b00, 8'h28, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0);
        @(negedge clk);
        check("send data on bus", 32'(bus_o.data), 32'(8'hD7));
        check("send atn low", 32'(bus_o.atn), 32'(0));
        wait_done(5000, "send $28");
      end
    join
    check("settle ticks in 32..34", 32'(settle_ticks >= 32 && settle_ticks <= 34), 32'(1));
    check("send released data", 32'(bus_o.data), 32'(8'hFF));
    check("send released eoi", 32'(bus_o.eoi), 32'(1));
    check("atn still latched", 32'(bus_o.atn), 32'(0));

    // Receive refused while ATN is latched; handshake lines untouched.
    issue(2'b01, 8'h00, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0);
    wait_done(100, "receive under atn");
    check("refused rx nrfd", 32'(bus_o.nrfd), 32'(1));
    check("refused rx ndac", 32'(bus_o.ndac), 32'(1));

    // No device present.
    dev = BUS_RELEASED;
    issue(2'b00, 8'h55, 1'b0, 1'b0, 2'b10, 8'h00, 1'b0);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin
      lat++;
      @(negedge clk);
    end
    check("no-device latency", 32'(lat), 32'(1));
    wait_done(100, "no-device send");
    check("no-device dav never low", 32'(dav_seen), 32'(0));

    // Listener never releases NDAC.
    dev = BUS_RELEASED;
    dev.ndac = 1'b0;
    issue(2'b00, 8'h0F, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0);
    wait_done(5000, "stuck listener");
    check("dav low ce ticks", 32'(dav_low_ticks), 32'(1024));
    check("timeout data released", 32'(bus_o.data), 32'(8'hFF));
    check("timeout eoi released", 32'(bus_o.eoi), 32'(1));

    // Release ATN.
    issue(2'b11, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    wait_done(100, "release atn");
    check("atn released", 32'(bus_o.atn), 32'(1));

    // Receive $41 with EOI.
    fork
      talker(8'h41, 1'b1, 1'b0);
      begin
        issue(2'b01, 8'h00, 1'b0, 1'b0, 2'b00, 8'h41, 1'b1);
        wait_done(5000, "receive $41");
      end
    join
    check("rx data literal", 32'(rsp_data), 32'(8'h41));
    check("rx eoi literal", 32'(rsp_eoi), 32'(1));
    check("rx nrfd held low", 32'(bus_o.nrfd), 32'(0));
    check("rx ndac asserted", 32'(bus_o.ndac), 32'(0));

    // Talker holds DAV: acceptor times out with the byte already latched.
    fork
      talker(8'h96, 1'b0, 1'b1);
      begin
        issue(2'b01, 8'h00, 1'b0, 1'b0, 2'b01, 8'h96, 1'b0);
        wait_done(5000, "receive timeout");
      end
    join
    dev = BUS_RELEASED;
    check("rx timeout ndac", 32'(bus_o.ndac), 32'(0));

    // Latch ATN (no device), then IFC.
    issue(2'b00, 8'h01, 1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
    wait_done(100, "atn latch send");
    issue(2'b10, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
    @(negedge clk);
    check("ifc low at start", 32'(bus_o.ifc), 32'(0));
    check("ifc releases atn", 32'(bus_o.atn), 32'(1));
    wait_done(5000, "ifc");
    check("ifc low ce ticks", 32'(ifc_low_ticks), 32'(1600));

    // Reset in the middle of a send.
    dev.ndac = 1'b0;
    issue(2'b00, 8'hAA, 1'b1, 1'b1, 2'b00, 8'h00, 1'b0);
    wait_bus(0, 1'b0, 300, "dav before reset");
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    model_atn = 1'b1; model_rx = 8'h00; model_eoi = 1'b0; model_status = 2'b00;
    @(posedge clk);
    #1;
    check("mid-op reset bus_o", 32'(bus_o), 32'(16'hFFFF));
    check("mid-op reset rsp_valid", 32'(rsp_valid), 32'(0));
    check("mid-op reset busy", 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dev = BUS_RELEASED;
    repeat (20) @(negedge clk);
    check("expected queue drained", 32'(exp_q.size()), 32'(0));

    summary();
    $finish;
  end

endmodule
